// File: rtl/interval_meter.sv
// Times the gap from a start edge to a (possibly asynchronous) stop edge in clk cycles,
// with optional timeout, saturation flag and a result held until acknowledged.
module interval_meter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop_in,
    input  logic [WIDTH-1:0] timeout_limit,
    input  logic             result_ack,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result_count,
    output logic             result_timeout,
    output logic             result_saturated
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("interval_meter: SYNC_STAGES must be in 2..4");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   start_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out_q;
    logic [WIDTH-1:0]       count_q, count_d;
    logic [WIDTH-1:0]       limit_q, limit_d;
    logic [WIDTH-1:0]       res_count_q, res_count_d;
    logic                   res_timeout_q, res_timeout_d;
    logic                   res_sat_q, res_sat_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;

    logic start_rise;
    logic stop_rise;

    assign start_rise = start & ~start_q;
    assign stop_rise  = sync_q[SYNC_STAGES-1] & ~sync_out_q;

    // Edge-detect history and stop_in synchronizer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q    <= 1'b0;
            sync_q     <= '0;
            sync_out_q <= 1'b0;
        end else begin
            start_q    <= start;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], stop_in};
            sync_out_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            limit_q       <= '0;
            res_count_q   <= '0;
            res_timeout_q <= 1'b0;
            res_sat_q     <= 1'b0;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            limit_q       <= limit_d;
            res_count_q   <= res_count_d;
            res_timeout_q <= res_timeout_d;
            res_sat_q     <= res_sat_d;
            busy_q        <= busy_d;
            valid_q       <= valid_d;
        end
    end

    // Next-state: abort beats stop, stop beats timeout, otherwise count up without wrapping.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        limit_d       = limit_q;
        res_count_d   = res_count_q;
        res_timeout_d = res_timeout_q;
        res_sat_d     = res_sat_q;

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d       = MEASURE;
                    count_d       = '0;
                    limit_d       = timeout_limit;
                    res_timeout_d = 1'b0;
                    res_sat_d     = 1'b0;
                end
            end
            MEASURE: begin
                if (!start) begin
                    state_d = IDLE;
                end else if (stop_rise) begin
                    res_count_d   = count_q;
                    res_timeout_d = 1'b0;
                    state_d       = DONE;
                end else if ((limit_q != '0) && (count_q == limit_q)) begin
                    res_count_d   = count_q;
                    res_timeout_d = 1'b1;
                    state_d       = DONE;
                end else if (count_q != CNT_MAX) begin
                    count_d = count_q + WIDTH'(1);
                end else begin
                    res_sat_d = 1'b1;
                end
            end
            DONE: begin
                if (result_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d == MEASURE);
        valid_d = (state_d == DONE);
    end

    assign busy             = busy_q;
    assign result_valid     = valid_q;
    assign result_count     = res_count_q;
    assign result_timeout   = res_timeout_q;
    assign result_saturated = res_sat_q;

endmodule

// File: tb/tb_interval_meter.sv
// Scoreboard bench for interval_meter (WIDTH=8, SYNC_STAGES=2): directed scenarios push
// expected results; a negedge monitor checks each result_valid rise against the queue.
module tb_interval_meter;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         stop_in;
    logic [W-1:0] timeout_limit;
    logic         result_ack;
    logic         busy;
    logic         result_valid;
    logic [W-1:0] result_count;
    logic         result_timeout;
    logic         result_saturated;

    interval_meter #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .stop_in          (stop_in),
        .timeout_limit    (timeout_limit),
        .result_ack       (result_ack),
        .busy             (busy),
        .result_valid     (result_valid),
        .result_count     (result_count),
        .result_timeout   (result_timeout),
        .result_saturated (result_saturated)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int e0     = 0;

    typedef struct {
        logic [W-1:0] cnt;
        logic         to;
        logic         sat;
        int           at_edge;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] cnt, input logic to, input logic sat, input int rel);
        exp_t e;
        e.cnt     = cnt;
        e.to      = to;
        e.sat     = sat;
        e.at_edge = e0 + rel;
        sb.push_back(e);
    endtask

    // Monitor: every rising result_valid must match the oldest expected result.
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (result_valid && !valid_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got count %0d with no result expected", result_count);
            end else begin
                e = sb.pop_front();
                chk("res_count", 32'(result_count), 32'(e.cnt));
                chk("res_timeout", 32'(result_timeout), 32'(e.to));
                chk("res_saturated", 32'(result_saturated), 32'(e.sat));
                chk("res_edge", 32'(cyc), 32'(e.at_edge));
            end
        end
        valid_prev = result_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: the following posedge is edge 0 of the measurement.
    task automatic begin_meas(input logic [W-1:0] lim);
        timeout_limit = lim;
        start         = 1'b1;
        e0            = cyc + 1;
    endtask

    // Advance to the negedge just before edge k of the current measurement.
    task automatic to_edge(input int k);
        while (cyc < e0 + k - 1) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n;
        n = 0;
        while (!result_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(result_valid), 32'd1);
    endtask

    task automatic ack();
        result_ack = 1'b1;
        tick(1);
        result_ack = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_valid"}, 32'(result_valid), 32'd0);
        chk({name, "_count"}, 32'(result_count), 32'd0);
        chk({name, "_timeout"}, 32'(result_timeout), 32'd0);
        chk({name, "_saturated"}, 32'(result_saturated), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        stop_in       = 1'b0;
        result_ack    = 1'b0;
        timeout_limit = '0;
        tick(2);
        chk_all_zero("reset");
        reset = 1'b0;
        tick(2);

        // Stop sampled at edge 10 -> count 11, valid at edge 12.
        begin_meas(8'd100);
        push_exp(8'd11, 1'b0, 1'b0, 12);
        to_edge(5);
        chk("t1_busy", 32'(busy), 32'd1);
        to_edge(10);
        stop_in = 1'b1;
        wait_valid(10, "t1_valid_rise");
        chk("t1_busy_done", 32'(busy), 32'd0);
        ack();
        chk("t1_valid_after_ack", 32'(result_valid), 32'd0);
        start   = 1'b0;
        stop_in = 1'b0;
        tick(3);

        // Timeout at limit 20; start re-rising in DONE is not queued.
        begin_meas(8'd20);
        push_exp(8'd20, 1'b1, 1'b0, 21);
        wait_valid(30, "t2_valid_rise");
        start = 1'b0;
        tick(1);
        start = 1'b1;
        tick(4);
        chk("t2_hold_valid", 32'(result_valid), 32'd1);
        chk("t2_hold_busy", 32'(busy), 32'd0);
        chk("t2_hold_count", 32'(result_count), 32'd20);
        ack();
        tick(3);
        chk("t2_no_requeue_busy", 32'(busy), 32'd0);
        chk("t2_no_requeue_valid", 32'(result_valid), 32'd0);
        start = 1'b0;
        tick(2);

        // Stop edge coincides with count == limit: stop wins.
        begin_meas(8'd11);
        push_exp(8'd11, 1'b0, 1'b0, 12);
        to_edge(10);
        stop_in = 1'b1;
        wait_valid(10, "t3_valid_rise");
        ack();
        start   = 1'b0;
        stop_in = 1'b0;
        tick(3);

        // Abort at edge 5 keeps the previous result, then a fresh measurement.
        begin_meas(8'd50);
        to_edge(5);
        start = 1'b0;
        tick(3);
        chk("t4_abort_busy", 32'(busy), 32'd0);
        chk("t4_abort_valid", 32'(result_valid), 32'd0);
        chk("t4_abort_count", 32'(result_count), 32'd11);
        chk("t4_abort_timeout", 32'(result_timeout), 32'd0);
        begin_meas(8'd30);
        push_exp(8'd4, 1'b0, 1'b0, 5);
        to_edge(3);
        stop_in = 1'b1;
        wait_valid(10, "t4_valid_rise");
        ack();
        start   = 1'b0;
        stop_in = 1'b0;
        tick(3);

        // Limit 0: counter saturates at 255 and keeps measuring until stop.
        begin_meas(8'd0);
        to_edge(300);
        chk("t5_sat_busy", 32'(busy), 32'd1);
        chk("t5_sat_valid", 32'(result_valid), 32'd0);
        chk("t5_sat_flag", 32'(result_saturated), 32'd1);
        push_exp(8'd255, 1'b0, 1'b1, 302);
        stop_in = 1'b1;
        wait_valid(10, "t5_valid_rise");
        ack();
        start   = 1'b0;
        stop_in = 1'b0;
        tick(3);

        // Asynchronous reset during MEASURE.
        begin_meas(8'd100);
        to_edge(5);
        reset = 1'b1;
        start = 1'b0;
        #1;
        chk_all_zero("t6_reset_measure");
        tick(1);
        reset = 1'b0;
        tick(2);

        // Asynchronous reset during DONE.
        begin_meas(8'd5);
        push_exp(8'd5, 1'b1, 1'b0, 6);
        wait_valid(10, "t6_valid_rise");
        reset = 1'b1;
        start = 1'b0;
        #1;
        chk_all_zero("t6_reset_done");
        tick(1);
        reset = 1'b0;
        tick(2);

        // stop_in pulse while IDLE produces nothing.
        stop_in = 1'b1;
        tick(3);
        stop_in = 1'b0;
        tick(5);
        chk("t7_glitch_busy", 32'(busy), 32'd0);
        chk("t7_glitch_valid", 32'(result_valid), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/interval_meter.md
Name: interval_meter

Overview:
- Measures the delay, in clk cycles, from a start command to an external response edge. It is the measuring end of the programmable-delay path: it times a delayed or toggled signal rather than generating one.
- Captures the count, flags a timeout, and holds the result until software acknowledges it.
- Sits between the control/register block (start, limit, ack) and a possibly asynchronous stop source.

Parameters:
- WIDTH, 32, width of the counter, the limit and the result.
- SYNC_STAGES, 2, number of synchronizer flops on stop_in; legal values are 2..4.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- start  input  1  synchronous level; its rising edge arms a measurement, and holding it high keeps the measurement alive.
- stop_in  input  1  asynchronous response signal; its rising edge ends the measurement.
- timeout_limit  input  WIDTH  cycle limit; 0 disables the timeout.
- result_ack  input  1  consumes the held result.
- busy  output  1  high while in MEASURE.
- result_valid  output  1  high while in DONE.
- result_count  output  WIDTH  captured count.
- result_timeout  output  1  result was produced by the timeout.
- result_saturated  output  1  counter reached all-ones with the timeout disabled.

Behaviour:
- Reset values:
  - state IDLE; count 0; latched limit 0; all synchronizer and edge-detect flops 0.
  - busy=0, result_valid=0, result_count=0, result_timeout=0, result_saturated=0.
- Edge detection:
  - start_rise = start & ~start_q, with start_q registered every cycle.
  - stop_in passes through SYNC_STAGES flops; stop_rise = sync_out & ~sync_out_q.
- FSM states: IDLE, MEASURE, DONE.
- IDLE:
  - On start_rise: go to MEASURE, count<=0, latch timeout_limit, clear result_timeout and result_saturated.
  - stop_rise in IDLE is ignored.
- MEASURE (evaluated in priority order each cycle):
  - start==0 → abort: go to IDLE; no result; result_* registers unchanged.
  - stop_rise → result_count<=count, result_timeout<=0, go to DONE.
  - Latched limit !=0 and count==limit → result_count<=count, result_timeout<=1, go to DONE.
  - Otherwise: count<=count+1. With limit==0 the counter saturates at all-ones and sets result_saturated<=1; it stays in MEASURE until stop or abort.
  - stop_rise and the limit match in the same cycle → stop wins, result_timeout=0.
- DONE:
  - result_valid=1; result_* are held stable.
  - result_ack → IDLE on the next edge. result_ack is ignored in IDLE and MEASURE.
  - start_rise in DONE is ignored and is not queued. A new measurement requires start to go low and then rise again after returning to IDLE.
- Latency:
  - Start edge sampled at edge 0, stop_in first sampled high at edge N → result_count = N + SYNC_STAGES − 1.
  - result_valid rises at edge N + SYNC_STAGES.
- Timeout:
  - With limit L, result_valid rises at edge L+1 after the start edge, with result_count=L.
  - Changing timeout_limit during MEASURE has no effect.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); any held result is discarded.
- Width rules:
  - count and limit are unsigned WIDTH-bit.
  - The increment never wraps, so all-ones is held.

Test Plan:
- SYNC_STAGES=2, limit=100: start rises at edge 0 and is held, stop_in rises before edge 10 → result_valid at edge 12, result_count=11, result_timeout=0; ack → IDLE, result_valid=0.
- limit=20, stop_in held low → result_valid at edge 21, result_count=20, result_timeout=1; start_rise while in DONE is ignored until ack.
- Stop edge timed to coincide with count==limit (limit=11, stop_in high before edge 10) → result_count=11, result_timeout=0.
- start dropped at edge 5 during MEASURE → IDLE, result_valid stays 0, previous result_count unchanged; the next start_rise measures correctly.
- WIDTH=8, limit=0, no stop → count holds 255, result_saturated=1 and busy stays high; stop edge then → result_count=255.
- Assert reset during MEASURE and during DONE → all outputs 0 at once; stop_in glitch in IDLE → no response.
